// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write-back path.
package rf_pkg;

    localparam int RF_XLEN   = 32;
    localparam int RF_REG_AW = 5;

    // Round-robin pointer: which producer wins when both request.
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } arb_state_e;

    // One registered write command toward the register file.
    typedef struct packed {
        logic                 we;
        logic [RF_REG_AW-1:0] waddr;
        logic [RF_XLEN-1:0]   wdata;
    } wr_cmd_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits for issue-stage RAW/WAW stalls.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int REG_AW = RF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] busy_q, busy_d;

    // Clear on write-back, then set on issue so a same-cycle set wins; r0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin ALU/LSU arbitration onto the single
// register-file write port, registered write command, pending scoreboard.
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int REG_AW = RF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    arb_state_e ptr_q, ptr_d;
    wr_cmd_t    cmd_q, cmd_d;
    logic       grant_alu, grant_lsu;

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= PRI_ALU;
        else       ptr_q <= ptr_d;
    end

    // Pointer moves past whoever was just granted; idle cycles hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_alu)      ptr_d = PRI_LSU;
        else if (grant_lsu) ptr_d = PRI_ALU;
    end

    // Grants: lone requester wins, ties go to the pointer; nothing during reset.
    always_comb begin
        grant_alu = !reset && alu_valid && (!lsu_valid || ptr_q == PRI_ALU);
        grant_lsu = !reset && lsu_valid && (!alu_valid || ptr_q == PRI_LSU);
        alu_ready = grant_alu;
        lsu_ready = grant_lsu;
    end

    // Build the next write command; rd==0 is consumed without a write.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        if (grant_alu) begin
            cmd_d.we    = (alu_rd != '0);
            cmd_d.waddr = alu_rd;
            cmd_d.wdata = alu_data;
        end else if (grant_lsu) begin
            cmd_d.we    = (lsu_rd != '0);
            cmd_d.waddr = lsu_rd;
            cmd_d.wdata = lsu_data;
        end
    end

    // Write command register feeding the register file.
    always_ff @(posedge clk) begin
        if (reset) cmd_q <= '0;
        else       cmd_q <= cmd_d;
    end

    assign rf_we    = cmd_q.we;
    assign rf_waddr = cmd_q.waddr;
    assign rf_wdata = cmd_q.wdata;

    rf_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_i      (iss_valid),
        .set_addr_i (iss_rd),
        .clr_i      (cmd_q.we),
        .clr_addr_i (cmd_q.waddr),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy)
    );

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model.
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    rf_wb_ctrl dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_lsu_turn: LSU has the tie-break; m_busy: registers with a pending write;
    // m_we/m_waddr/m_wdata: what the register file should see this cycle.
    bit          m_lsu_turn;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    wire exp_alu_rdy = !reset && alu_valid && (!lsu_valid || !m_lsu_turn);
    wire exp_lsu_rdy = !reset && lsu_valid && (!alu_valid || m_lsu_turn);
    wire [31:0] clr_mask = m_we ? (32'd1 << m_waddr) : 32'd0;
    wire [31:0] set_mask = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_we       <= 1'b0;
            m_lsu_turn <= 1'b0;
            m_busy     <= 32'd0;
        end else begin
            m_we    <= (exp_alu_rdy && alu_rd != 5'd0) || (exp_lsu_rdy && lsu_rd != 5'd0);
            m_waddr <= exp_alu_rdy ? alu_rd : lsu_rd;
            m_wdata <= exp_alu_rdy ? alu_data : lsu_data;
            if (exp_alu_rdy)      m_lsu_turn <= 1'b1;
            else if (exp_lsu_rdy) m_lsu_turn <= 1'b0;
            m_busy <= (m_busy & ~clr_mask) | set_mask;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("alu_ready", alu_ready, exp_alu_rdy);
            check("lsu_ready", lsu_ready, exp_lsu_rdy);
            check("rf_we", rf_we, m_we);
            if (m_we) begin
                check("rf_waddr", rf_waddr, m_waddr);
                check("rf_wdata", rf_wdata, m_wdata);
            end
            check("rs1_busy", rs1_busy, m_busy[rs1_addr]);
            check("rs2_busy", rs2_busy, m_busy[rs2_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; lsu_valid = 0; iss_valid = 0;
        alu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        alu_data = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    int seq_exp [4] = '{1, 11, 2, 12};

    initial begin
        int a_i, l_i;
        bit hs_a, hs_l;
        idle_inputs();
        do_reset();
        cmp_en = 1;

        // Reset state
        @(negedge clk);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 32'd0);

        // Single ALU write, latency one cycle
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t1_we", rf_we, 1'b1);
        check("t1_waddr", rf_waddr, 5'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("t1_we_off", rf_we, 1'b0);

        // Both saturated: alternate grants starting with ALU
        do_reset();
        a_i = 1; l_i = 11;
        for (int c = 0; c < 5; c++) begin
            alu_valid = 1; alu_rd = 5'(a_i); alu_data = 32'(a_i * 16);
            lsu_valid = 1; lsu_rd = 5'(l_i); lsu_data = 32'(l_i * 16);
            @(negedge clk);
            if (c > 0) check("t2_waddr", rf_waddr, 5'(seq_exp[c-1]));
            if (c < 4) check("t2_alu_grant", alu_ready, (c % 2) == 0);
            hs_a = alu_ready; hs_l = lsu_ready;
            tick();
            if (hs_a) a_i++;
            if (hs_l) l_i++;
        end
        alu_valid = 0; lsu_valid = 0;

        // LSU to r0: consumed, no write, pointer back to ALU
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        @(negedge clk);
        check("t3_lsu_ready", lsu_ready, 1'b1);
        tick();
        alu_valid = 1; alu_rd = 3; lsu_valid = 1; lsu_rd = 4;
        @(negedge clk);
        check("t3_no_we", rf_we, 1'b0);
        check("t3_ptr_alu", alu_ready, 1'b1);
        tick();
        idle_inputs();
        tick(); tick();

        // Scoreboard set/clear timing
        iss_valid = 1; iss_rd = 7; rs1_addr = 7;
        @(negedge clk);
        check("t4_busy_pre", rs1_busy, 1'b0);
        tick();
        iss_valid = 0;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        @(negedge clk);
        check("t4_busy_set", rs1_busy, 1'b1);
        check("t4_lsu_ready", lsu_ready, 1'b1);
        tick();
        lsu_valid = 0;
        @(negedge clk);
        check("t4_busy_n1", rs1_busy, 1'b1);
        tick();
        @(negedge clk);
        check("t4_busy_n2", rs1_busy, 1'b0);

        // Same-cycle set and clear: set wins
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        lsu_valid = 1; lsu_rd = 7;
        tick();
        lsu_valid = 0;
        iss_valid = 1; iss_rd = 7;
        @(negedge clk);
        check("t4b_we7", rf_waddr, 5'd7);
        tick();
        iss_valid = 0;
        @(negedge clk);
        check("t4b_busy_kept", rs1_busy, 1'b1);
        alu_valid = 1; alu_rd = 7;
        tick();
        alu_valid = 0;
        tick(); tick();

        // Issue to r0 never marks busy
        iss_valid = 1; iss_rd = 0; rs2_addr = 0;
        tick();
        iss_valid = 0;
        @(negedge clk);
        check("t5_r0_busy", rs2_busy, 1'b0);

        // Reset during a request: no write, busy cleared, pointer reset
        iss_valid = 1; iss_rd = 9; rs1_addr = 9;
        tick();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; reset = 1;
        @(negedge clk);
        check("t6_rdy_in_rst", alu_ready, 1'b0);
        tick();
        reset = 0; alu_valid = 0;
        @(negedge clk);
        check("t6_we", rf_we, 1'b0);
        check("t6_busy", rs1_busy, 1'b0);
        // Pointer was PRI_LSU before reset (last grant was ALU rd=7)
        alu_valid = 1; alu_rd = 2; lsu_valid = 1; lsu_rd = 3;
        tick();
        idle_inputs();

        // Randomized traffic with hold-until-ready producers
        hs_a = 1; hs_l = 1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (hs_a || !alu_valid) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (hs_l || !lsu_valid) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            @(negedge clk);
            hs_a = alu_valid && alu_ready;
            hs_l = lsu_valid && lsu_ready;
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
